// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard MMIO responder: frame FSM encoding,
// register offsets, STATUS bit layout and the odd-parity helper.
package kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int STAT_NE_BIT   = 0;
    localparam int STAT_FULL_BIT = 1;
    localparam int STAT_OVF_BIT  = 2;
    localparam int STAT_ERR_BIT  = 3;
    localparam int STAT_CNT_LSB  = 8;
    localparam int STAT_CNT_W    = 8;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Scancode FIFO: power-of-two depth, pointers wrap naturally, push and pop
// may coincide on a full FIFO.
module kbd_fifo
    import kbd_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [7:0]    head
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A pop frees the slot the simultaneous push needs when full.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/kbd_mmio_responder.sv
// PS/2 keyboard receiver with scancode FIFO and DATA/STATUS MMIO registers.
// Define KBD_PARITY_CHECK_EN to reject frames failing odd parity.
module kbd_mmio_responder
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        sel,
    input  logic        rd,
    input  logic        reg_off,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic                  ps2_clk_s1_q, ps2_clk_s2_q;
    logic                  ps2_data_s1_q, ps2_data_s2_q;
    logic [FILTER_LEN-1:0] clk_hist_q, clk_hist_d;
    logic [FILTER_LEN-1:0] data_hist_q, data_hist_d;
    logic                  filt_clk_q, filt_clk_d;
    logic                  filt_data_q, filt_data_d;
    logic                  filt_clk_dly_q;
    logic                  fall;

    frame_state_t          state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shreg_q, shreg_d;
    logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic                  push_q, push_d;
    logic                  timeout, frame_ok, frame_err;
`ifdef KBD_PARITY_CHECK_EN
    logic                  par_q, par_d;
`endif

    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [7:0]            fifo_head;
    logic                  strobe, data_rd, stat_rd;
    logic                  ovf_q, ovf_d, err_q, err_d;
    logic                  ovf_set;
    logic [31:0]           status_word;
    logic [31:0]           rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    // Level filter: a line level is accepted only after FILTER_LEN (>= 2) equal samples.
    always_comb begin
        clk_hist_d  = {clk_hist_q[FILTER_LEN-2:0], ps2_clk_s2_q};
        data_hist_d = {data_hist_q[FILTER_LEN-2:0], ps2_data_s2_q};
        filt_clk_d  = filt_clk_q;
        filt_data_d = filt_data_q;
        if (&clk_hist_d)       filt_clk_d  = 1'b1;
        else if (~|clk_hist_d) filt_clk_d  = 1'b0;
        if (&data_hist_d)       filt_data_d = 1'b1;
        else if (~|data_hist_d) filt_data_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk_s1_q   <= 1'b1;
            ps2_clk_s2_q   <= 1'b1;
            ps2_data_s1_q  <= 1'b1;
            ps2_data_s2_q  <= 1'b1;
            clk_hist_q     <= '1;
            data_hist_q    <= '1;
            filt_clk_q     <= 1'b1;
            filt_data_q    <= 1'b1;
            filt_clk_dly_q <= 1'b1;
        end else begin
            ps2_clk_s1_q   <= ps2_clk;
            ps2_clk_s2_q   <= ps2_clk_s1_q;
            ps2_data_s1_q  <= ps2_data;
            ps2_data_s2_q  <= ps2_data_s1_q;
            clk_hist_q     <= clk_hist_d;
            data_hist_q    <= data_hist_d;
            filt_clk_q     <= filt_clk_d;
            filt_data_q    <= filt_data_d;
            filt_clk_dly_q <= filt_clk_q;
        end
    end

    assign fall    = filt_clk_dly_q & ~filt_clk_q;
    assign timeout = (state_q != ST_IDLE) && !fall && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

`ifdef KBD_PARITY_CHECK_EN
    assign frame_ok = filt_data_q & odd_parity_ok(shreg_q, par_q);
`else
    assign frame_ok = filt_data_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            case (state_q)
                ST_IDLE:   if (!filt_data_q) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        push_d    = 1'b0;
        frame_err = timeout;
`ifdef KBD_PARITY_CHECK_EN
        par_d     = par_q;
`endif
        if (state_q == ST_IDLE || fall) tmo_cnt_d = '0;
        else                            tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (fall) begin
            case (state_q)
                ST_IDLE: bit_cnt_d = 3'd0;
                ST_DATA: begin
                    shreg_d   = {filt_data_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
`ifdef KBD_PARITY_CHECK_EN
                ST_PARITY: par_d = filt_data_q;
`endif
                ST_STOP: begin
                    if (frame_ok) push_d    = 1'b1;
                    else          frame_err = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // shreg stays stable in IDLE, so the push one cycle later still sees the byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'd0;
            tmo_cnt_q <= '0;
            push_q    <= 1'b0;
`ifdef KBD_PARITY_CHECK_EN
            par_q     <= 1'b0;
`endif
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tmo_cnt_q <= tmo_cnt_d;
            push_q    <= push_d;
`ifdef KBD_PARITY_CHECK_EN
            par_q     <= par_d;
`endif
        end
    end

    kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .pop   (data_rd),
        .wdata (shreg_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign strobe  = sel & rd;
    assign data_rd = strobe & (reg_off == REG_DATA);
    assign stat_rd = strobe & (reg_off == REG_STATUS);
    assign ovf_set = push_q & fifo_full & ~data_rd;

    always_comb begin
        status_word = 32'd0;
        status_word[STAT_NE_BIT]   = ~fifo_empty;
        status_word[STAT_FULL_BIT] = fifo_full;
        status_word[STAT_OVF_BIT]  = ovf_q;
        status_word[STAT_ERR_BIT]  = err_q;
        status_word[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
    end

    // New events win over the clear so they survive into the next STATUS read.
    always_comb begin
        ovf_d      = (ovf_q & ~stat_rd) | ovf_set;
        err_d      = (err_q & ~stat_rd) | frame_err;
        rd_valid_d = strobe;
        rd_data_d  = rd_data_q;
        if (data_rd)      rd_data_d = fifo_empty ? 32'd0 : {24'd0, fifo_head};
        else if (stat_rd) rd_data_d = status_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
        end else begin
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign irq      = ~fifo_empty;

endmodule

// File: tb/tb_kbd_mmio_responder.sv
// Randomized bench for kbd_mmio_responder against a queue-based model of the
// keyboard FIFO and sticky flags; parity rule follows KBD_PARITY_CHECK_EN.
module tb_kbd_mmio_responder;

    localparam int DEPTH   = 8;
    localparam int FLEN    = 4;
    localparam int TMO     = 300;
    localparam int H       = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        sel = 1'b0;
    logic        rd = 1'b0;
    logic        reg_off = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        irq;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_err = 1'b0;

    kbd_mmio_responder #(
        .FIFO_DEPTH  (DEPTH),
        .FILTER_LEN  (FLEN),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .sel      (sel),
        .rd       (rd),
        .reg_off  (reg_off),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    endtask

    function automatic logic good_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        ps2_data = b;
        wait_cyc(H);
        ps2_clk = 1'b0;
        wait_cyc(H);
        ps2_clk = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic p, input logic s);
        logic ok;
        ok = s;
`ifdef KBD_PARITY_CHECK_EN
        ok = ok && (^{b, p});
`endif
        if (!ok)                   m_err = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else                       m_ovf = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(p);
        drive_bit(s);
        ps2_data = 1'b1;
        wait_cyc(3 * H);
        model_frame(b, p, s);
    endtask

    task automatic send_partial(input int nbits);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
    endtask

    task automatic do_read(input logic off, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; rd = 1'b1; reg_off = off;
        @(negedge clk);
        sel = 1'b0; rd = 1'b0;
        chk("rd_valid_hi", {31'd0, rd_valid}, 32'd1);
        d = rd_data;
        @(negedge clk);
        chk("rd_valid_lo", {31'd0, rd_valid}, 32'd0);
        chk("rd_data_hold", rd_data, d);
    endtask

    task automatic read_data_chk(input string tag);
        logic [31:0] exp, d;
        exp = (mq.size() != 0) ? {24'd0, mq.pop_front()} : 32'd0;
        do_read(1'b0, d);
        chk(tag, d, exp);
    endtask

    task automatic read_stat_chk(input string tag);
        logic [31:0] exp, d;
        exp = 32'd0;
        exp[0] = (mq.size() != 0);
        exp[1] = (mq.size() == DEPTH);
        exp[2] = m_ovf;
        exp[3] = m_err;
        exp[15:8] = 8'(mq.size());
        m_ovf = 1'b0;
        m_err = 1'b0;
        do_read(1'b1, d);
        chk(tag, d, exp);
    endtask

    initial begin
        logic [7:0] b;
        int op;

        wait_cyc(3);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        wait_cyc(FLEN + 4);

        read_data_chk("empty_data");
        read_stat_chk("empty_status");

        send_frame(8'h1C, 1'b0, 1'b1);
        chk("irq_before", {31'd0, irq}, 32'd1);
        read_data_chk("data_1c");
        chk("irq_after", {31'd0, irq}, 32'd0);

        send_frame(8'h2B, good_parity(8'h2B), 1'b0);
        read_stat_chk("bad_stop_status");

        send_frame(8'h1C, 1'b1, 1'b1);
        read_stat_chk("bad_parity_status");
        read_data_chk("bad_parity_data");

        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            send_frame(b, good_parity(b), 1'b1);
        end
        read_stat_chk("ovf_status1");
        read_stat_chk("ovf_status2");
        for (int i = 0; i < DEPTH; i++) read_data_chk("drain");
        read_stat_chk("drained_status");

        send_partial(4);
        wait_cyc(TMO + 2 * H);
        m_err = 1'b1;
        send_frame(8'hF0, good_parity(8'hF0), 1'b1);
        read_stat_chk("timeout_status");
        read_data_chk("timeout_f0");
        read_data_chk("timeout_empty");

        // Short low pulse on ps2_clk with data low must not look like a start bit.
        ps2_data = 1'b0;
        wait_cyc(H);
        ps2_clk = 1'b0;
        wait_cyc(FLEN - 2);
        ps2_clk = 1'b1;
        wait_cyc(H);
        ps2_data = 1'b1;
        wait_cyc(H);
        send_frame(8'h5A, good_parity(8'h5A), 1'b1);
        read_stat_chk("glitch_status");
        read_data_chk("glitch_5a");

        send_frame(8'h11, good_parity(8'h11), 1'b1);
        send_partial(3);
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
        wait_cyc(FLEN + 4);
        read_stat_chk("midframe_rst_status");
        send_frame(8'h33, good_parity(8'h33), 1'b1);
        read_data_chk("after_rst_33");

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            if (op <= 1) begin
                b = 8'($urandom);
                send_frame(b, ($urandom_range(0, 7) == 0) ? ~good_parity(b) : good_parity(b),
                           ($urandom_range(0, 15) != 0));
            end else if (op == 2) begin
                read_data_chk("rand_data");
            end else begin
                read_stat_chk("rand_status");
            end
            chk("rand_irq", {31'd0, irq}, {31'd0, mq.size() != 0});
        end
        read_stat_chk("final_status");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
